ct_f_spsram_ctrl: RTL and testbench
===================================

// Module: ct_f_spsram_ctrl
// PURPOSE
//  Initiator for the FPGA single-port SRAM macro interface (A/CEN/GWEN/WEN/D -> Q).
//  After reset it sweeps every address writing INIT_VALUE, then grants a simple
//  client req/rdy port, translating active-high requests into the macro's active-low
//  strobes and returning read data one cycle later with rsp_vld.
// PARAMETERS
//  ADDR_WIDTH  10     SRAM address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  64     SRAM data width; bit-mask granularity 1 bit
//  INIT_VALUE  '0     DATA_WIDTH-wide word written to every address during init
// PORTS
//  CLK        in   1           single clock; all flops posedge CLK
//  RST        in   1           reset, asynchronous, active-high
//  req_vld    in   1           client request valid
//  req_wr     in   1           1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH  client address
//  req_wdata  in   DATA_WIDTH  client write data
//  req_wmask  in   DATA_WIDTH  active-high per-bit write enable
//  req_rdy    out  1           request accepted when req_vld & req_rdy
//  rsp_vld    out  1           read data valid (1-cycle pulse, no backpressure)
//  rsp_rdata  out  DATA_WIDTH  read data, = Q
//  init_done  out  1           init sweep finished; sticky until RST
//  init_err   out  1           readback mismatch seen (0 when macro off); sticky
//  A          out  ADDR_WIDTH  SRAM address
//  CEN        out  1           SRAM chip enable, active-low
//  GWEN       out  1           SRAM global write enable, active-low
//  WEN        out  DATA_WIDTH  SRAM per-bit write enable, active-low
//  D          out  DATA_WIDTH  SRAM write data
//  Q          in   DATA_WIDTH  SRAM read data, valid cycle after read strobe
// BEHAVIOUR
//  - Reset values: state=IDLE, cnt=0, req_rdy=0, rsp_vld=0, init_done=0, init_err=0,
//    CEN=1, GWEN=1, WEN='1, A=0, D=0. SRAM-side outputs decode combinationally
//    from state/cnt/request; in IDLE they hold the inactive reset values.
//  - FSM: IDLE -(1 cycle)-> INIT_WR -(cnt==all-ones)-> RUN (or INIT_RD with macro).
//  - INIT_WR: CEN=0,GWEN=0,WEN='0,A=cnt,D=INIT_VALUE; cnt++ each cycle, wraps to 0 on exit.
//  - RUN: req_rdy=1; CEN=!req_vld; GWEN=!(req_vld&req_wr); WEN=req_wr?~req_wmask:'1;
//    A=req_addr; D=req_wdata. Accepted read -> rsp_vld=1 next cycle, rsp_rdata=Q.
//    Back-to-back reads give rsp_vld every cycle. Write with wmask=0: strobes fire, no bit changes.
//  - Not RUN: req_rdy=0; pending client requests wait, no response generated.
//  - init_done registered: rises the first RUN cycle; client may issue in that cycle.
//  - RST mid-operation (any state): immediate return to reset values; re-run full init;
//    an in-flight rsp_vld is dropped.
// CONFIGURATION
//  CT_F_SPSRAM_CTRL_INIT_CHK_EN defined: after INIT_WR, state INIT_RD reads cnt
//    0..max (CEN=0,GWEN=1,WEN='1); each Q compared to INIT_VALUE the next cycle;
//    INIT_CHK (1 cycle) compares last word, then RUN. Any mismatch sets init_err.
//  Undefined: INIT_RD/INIT_CHK absent, init_err tied 0, RUN directly after INIT_WR.
// STRUCTURE
//  - Package ct_f_spsram_ctrl_pkg: state_e typedef (IDLE,INIT_WR,INIT_RD,INIT_CHK,RUN),
//    localparam encodings; shared by RTL and bench.
//  - Sub-module ct_f_spsram_init_chk (compare-pending flop, Q compare, sticky err),
//    instantiated only under CT_F_SPSRAM_CTRL_INIT_CHK_EN.
//  - Bench pairs this block with ct_f_spsram_1024x64 at default parameters.
// TESTING
//  1 Release RST at cycle 0, macro off -> 1024 writes of INIT_VALUE cycles 1..1024,
//    init_done=1 and req_rdy=1 from cycle 1025; every address reads back 0.
//  2 Write addr 0x155 data 0xDEAD_BEEF_0123_4567 mask '1, then read 0x155
//    -> rsp_vld one cycle after read accept, rsp_rdata=0xDEAD_BEEF_0123_4567.
//  3 Write 0x3FF data '1 mask 0x0000_0000_FFFF_FFFF after init
//    -> read returns 0x0000_0000_FFFF_FFFF; upper bits keep INIT_VALUE.
//  4 Reads to 0,1,2,3 on consecutive cycles -> rsp_vld high 4 consecutive cycles,
//    data in order; req_vld held during init -> no CEN low from client, no rsp_vld.
//  5 Assert RST at cycle 500 of INIT_WR -> outputs to reset values same cycle;
//    after release full sweep restarts at A=0, init_done 1025 cycles later.
//  6 Macro on, force Q bit 7 flipped at addr 0x20 during INIT_RD -> init_err=1
//    sticky; init_done at cycle 2050; with clean Q init_err stays 0.

Source files
------------

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared state encoding for the single-port SRAM initiator and its bench.
package ct_f_spsram_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        INIT_WR  = 3'd1,
        INIT_RD  = 3'd2,
        INIT_CHK = 3'd3,
        RUN      = 3'd4
    } state_e;

endpackage

// File: rtl/ct_f_spsram_1024x64.sv
// Behavioural single-port SRAM macro: active-low CEN/GWEN, per-bit active-low WEN,
// registered read data; Q holds its value across write cycles.
module ct_f_spsram_1024x64 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/ct_f_spsram_init_chk.sv
// Init readback checker: compares each returned word against INIT_VALUE one cycle
// after its read strobe and latches a sticky error flag.
module ct_f_spsram_init_chk #(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] Q,
    output logic                  err
);

    logic cmp_pend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmp_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            cmp_pend <= rd_en;
            if (cmp_pend && (Q != INIT_VALUE)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ct_f_spsram_ctrl.sv
// Single-port SRAM initiator: init sweep of INIT_VALUE, then client req/rdy pass-through.
// Define CT_F_SPSRAM_CTRL_INIT_CHK_EN to add a readback check of the init sweep.
module ct_f_spsram_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  req_rdy,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  cnt_max;

    assign cnt_max = (cnt == '1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_vld   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_vld   <= (state == RUN) && req_vld && !req_wr;
            init_done <= init_done || (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_rdy   = 1'b0;
        CEN       = 1'b1;
        GWEN      = 1'b1;
        WEN       = '1;
        A         = '0;
        D         = '0;
        case (state)
            IDLE: begin
                state_nxt = INIT_WR;
            end
            INIT_WR: begin
                CEN     = 1'b0;
                GWEN    = 1'b0;
                WEN     = '0;
                A       = cnt;
                D       = INIT_VALUE;
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt_max) begin
`ifdef CT_F_SPSRAM_CTRL_INIT_CHK_EN
                    state_nxt = INIT_RD;
`else
                    state_nxt = RUN;
`endif
                end
            end
`ifdef CT_F_SPSRAM_CTRL_INIT_CHK_EN
            INIT_RD: begin
                CEN     = 1'b0;
                A       = cnt;
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt_max) begin
                    state_nxt = INIT_CHK;
                end
            end
            INIT_CHK: begin
                state_nxt = RUN;
            end
`endif
            RUN: begin
                req_rdy = 1'b1;
                CEN     = !req_vld;
                GWEN    = !(req_vld && req_wr);
                WEN     = req_wr ? ~req_wmask : '1;
                A       = req_addr;
                D       = req_wdata;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rsp_rdata = Q;

`ifdef CT_F_SPSRAM_CTRL_INIT_CHK_EN
    ct_f_spsram_init_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_init_chk (
        .CLK   (CLK),
        .RST   (RST),
        .rd_en (state == INIT_RD),
        .Q     (Q),
        .err   (init_err)
    );
`else
    assign init_err = 1'b0;
`endif

endmodule

// File: tb/tb_ct_f_spsram_ctrl.sv
// Directed bench for ct_f_spsram_ctrl paired with the 1024x64 SRAM model; read
// responses are checked through an expected-data/expected-cycle scoreboard.
module tb_ct_f_spsram_ctrl;
    import ct_f_spsram_ctrl_pkg::*;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam logic [DW-1:0] INITV = '0;
`ifdef CT_F_SPSRAM_CTRL_INIT_CHK_EN
    localparam int  INIT_CYC = 2050;
    localparam bit  CHK_ON   = 1'b1;
`else
    localparam int  INIT_CYC = 1025;
    localparam bit  CHK_ON   = 1'b0;
`endif
    // Word at 0x20 is read in cycle 1025+32, its Q shows up the cycle after.
    localparam int FLIP_CYC = 1025 + 32 + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_vld, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_wmask;
    logic          req_rdy, rsp_vld, init_done, init_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] A;
    logic          CEN, GWEN;
    logic [DW-1:0] WEN, D, sram_q, qflip, dut_q;

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;
    logic [DW-1:0] sb_data[$];
    int            sb_cyc[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) gcyc <= gcyc + 1;

    assign dut_q = sram_q ^ qflip;

    ct_f_spsram_ctrl dut (
        .CLK (CLK), .RST (RST),
        .req_vld (req_vld), .req_wr (req_wr), .req_addr (req_addr),
        .req_wdata (req_wdata), .req_wmask (req_wmask), .req_rdy (req_rdy),
        .rsp_vld (rsp_vld), .rsp_rdata (rsp_rdata),
        .init_done (init_done), .init_err (init_err),
        .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D), .Q (dut_q)
    );

    ct_f_spsram_1024x64 u_sram (
        .CLK (CLK), .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D), .Q (sram_q)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (!RST && rsp_vld) begin
            if (sb_data.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_data", rsp_rdata, sb_data.pop_front());
                chk("rsp_cycle", gcyc, sb_cyc.pop_front());
            end
        end
    end

    task automatic apply_reset;
        RST = 1'b1;
        #1;
        chk("reset_vals", {req_rdy, rsp_vld, init_done, init_err, CEN, GWEN, WEN, A, D},
            {4'b0000, 2'b11, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}});
        sb_data.delete();
        sb_cyc.delete();
        req_vld   = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 10'h005;
        req_wdata = '0;
        req_wmask = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Walks cycles 0..upto after reset release, checking the SRAM strobes and status.
    task automatic run_init(input int upto, input bit flip);
        logic err_exp;
        for (int n = 0; n <= upto; n++) begin
            qflip = (flip && n == FLIP_CYC) ? 64'h80 : '0;
            if (n == 0) begin
                chk("idle_strobes", {CEN, GWEN, WEN, A}, {2'b11, {DW{1'b1}}, {AW{1'b0}}});
            end else if (n <= 1024) begin
                chk("init_wr", {CEN, GWEN, WEN, A, D}, {2'b00, {DW{1'b0}}, AW'(n - 1), INITV});
            end else if (CHK_ON && n <= 2048) begin
                chk("init_rd", {CEN, GWEN, WEN, A}, {2'b01, {DW{1'b1}}, AW'(n - 1025)});
            end else if (n == INIT_CYC) begin
                chk("first_run", {CEN, GWEN, WEN, A}, {2'b01, {DW{1'b1}}, 10'h005});
            end
            err_exp = CHK_ON && flip && (n > FLIP_CYC);
            chk("status", {req_rdy, rsp_vld, init_done, init_err},
                {n == INIT_CYC, 1'b0, n == INIT_CYC, err_exp});
            if (n == INIT_CYC) begin
                sb_data.push_back(INITV);
                sb_cyc.push_back(gcyc + 1);
            end
            if (n < upto) tick();
        end
        qflip = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = a;
        sb_data.push_back(exp);
        sb_cyc.push_back(gcyc + 1);
        tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        #1;
        chk("wr_strobes", {CEN, GWEN, WEN, A, D}, {2'b00, ~m, a, d});
        tick();
        req_vld = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; qflip = '0;
        @(negedge CLK);
        @(negedge CLK);

        apply_reset();
        run_init(INIT_CYC, 1'b0);
        tick();
        req_vld = 1'b0;

        for (int a = 0; a < 1024; a++) rd(AW'(a), INITV);
        req_vld = 1'b0;
        tick();

        wr(10'h155, 64'hDEAD_BEEF_0123_4567, '1);
        rd(10'h155, 64'hDEAD_BEEF_0123_4567);
        req_vld = 1'b0;
        wr(10'h155, 64'h0, '0);
        rd(10'h155, 64'hDEAD_BEEF_0123_4567);
        req_vld = 1'b0;
        wr(10'h3FF, '1, 64'h0000_0000_FFFF_FFFF);
        rd(10'h3FF, 64'h0000_0000_FFFF_FFFF);
        rd(10'h000, INITV);
        rd(10'h001, INITV);
        rd(10'h002, INITV);
        rd(10'h003, INITV);
        req_vld = 1'b0;
        tick();
        tick();

        // In-flight response must vanish when reset hits.
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'h007;
        @(posedge CLK);
        #1;
        chk("inflight_vld", rsp_vld, 1'b1);
        apply_reset();

        run_init(500, 1'b0);
        apply_reset();
        run_init(INIT_CYC, 1'b1);
        tick();
        req_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("err_sticky", {init_done, init_err}, {1'b1, CHK_ON});
            tick();
        end
        rd(10'h155, INITV);
        rd(10'h3FF, INITV);
        req_vld = 1'b0;
        tick();
        tick();
        chk("sb_drained", sb_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
